// File: rtl/bird_update.sv
// Bird physics stage: flap/gravity velocity step and clamped position update.
// Optional BIRD_PIXEL_EN adds a combinational bird sprite hit test.
module bird_update #(
   parameter int START_Y  = 240,
   parameter int TOP_Y    = 0,
   parameter int FLOOR_Y  = 440,
   parameter int GRAVITY  = 1,
   parameter int FLAP_V   = 8,
   parameter int MAX_FALL = 10,
   parameter int TICK_DIV = 833333
`ifdef BIRD_PIXEL_EN
   ,
   parameter int BIRD_X   = 160,
   parameter int BIRD_W   = 34,
   parameter int BIRD_H   = 24
`endif
) (
   input  logic       clk,
   input  logic       resetGame_n,
   input  logic       press,
   input  logic       update_bird,
   output logic       birdfinish,
   output logic [8:0] bird_y,
   output logic [7:0] bird_vel,
   output logic       on_ground
`ifdef BIRD_PIXEL_EN
   ,
   input  logic [9:0] x,
   input  logic [8:0] y,
   output logic       bird_pixel
`endif
);

   localparam int CW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
   localparam logic signed [8:0] GRAV9 = 9'(GRAVITY);
   localparam logic signed [8:0] MAXF9 = 9'(MAX_FALL);
   localparam logic signed [7:0] FLAPV = 8'(-FLAP_V);
   localparam logic signed [10:0] TOP11 = 11'(TOP_Y);
   localparam logic signed [10:0] FLR11 = 11'(FLOOR_Y);
   localparam logic [8:0] TOP9 = 9'(TOP_Y);
   localparam logic [8:0] FLR9 = 9'(FLOOR_Y);
   localparam logic [8:0] START9 = 9'(START_Y);

   typedef enum logic [2:0] {
      S_IDLE,
      S_VEL,
      S_POS,
      S_DONE,
      S_WAIT
   } state_t;

   state_t state_q, state_d;
   logic [CW-1:0] tick_cnt_q, tick_cnt_d;
   logic tick_pend_q, tick_pend_d;
   logic flap_pend_q, flap_pend_d;
   logic press_q;
   logic [8:0] bird_y_q, bird_y_d;
   logic [7:0] bird_vel_q, bird_vel_d;
   logic on_ground_q, on_ground_d;

   logic wrap;
   logic consume;
   logic press_edge;
   logic signed [8:0] v9;
   logic signed [10:0] sum;

   assign wrap = (tick_cnt_q == LAST);
   assign press_edge = press & ~press_q;
   assign v9 = $signed({bird_vel_q[7], bird_vel_q}) + GRAV9;
   assign sum = $signed({2'b00, bird_y_q})
              + $signed({{3{bird_vel_q[7]}}, bird_vel_q});

   // Tick divider and pending-event flags; a new event beats consumption.
   always_comb begin
      tick_cnt_d = wrap ? '0 : tick_cnt_q + CW'(1);
      tick_pend_d = wrap | (tick_pend_q & ~consume);
      flap_pend_d = press_edge | (flap_pend_q & ~consume);
   end

   // Next-state logic for the update handshake FSM.
   always_comb begin
      state_d = state_q;
      consume = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (update_bird)
               state_d = tick_pend_q ? S_VEL : S_DONE;
         end
         S_VEL: begin
            consume = 1'b1;
            state_d = S_POS;
         end
         S_POS:  state_d = S_DONE;
         S_DONE: state_d = S_WAIT;
         S_WAIT: begin
            if (!update_bird)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Physics datapath: velocity in S_VEL, clamped position in S_POS.
   always_comb begin
      bird_vel_d = bird_vel_q;
      bird_y_d = bird_y_q;
      on_ground_d = on_ground_q;
      if (state_q == S_VEL) begin
         if (flap_pend_q)
            bird_vel_d = FLAPV;
         else if (v9 > MAXF9)
            bird_vel_d = MAXF9[7:0];
         else
            bird_vel_d = v9[7:0];
      end
      if (state_q == S_POS) begin
         if (sum < TOP11) begin
            bird_y_d = TOP9;
            bird_vel_d = '0;
         end else if (sum >= FLR11) begin
            bird_y_d = FLR9;
            bird_vel_d = '0;
         end else begin
            bird_y_d = sum[8:0];
         end
         on_ground_d = (bird_y_d == FLR9);
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge resetGame_n) begin
      if (!resetGame_n) begin
         state_q <= S_IDLE;
         tick_cnt_q <= '0;
         tick_pend_q <= 1'b0;
         flap_pend_q <= 1'b0;
         press_q <= 1'b0;
         bird_y_q <= START9;
         bird_vel_q <= '0;
         on_ground_q <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_cnt_q <= tick_cnt_d;
         tick_pend_q <= tick_pend_d;
         flap_pend_q <= flap_pend_d;
         press_q <= press;
         bird_y_q <= bird_y_d;
         bird_vel_q <= bird_vel_d;
         on_ground_q <= on_ground_d;
      end
   end

   assign birdfinish = (state_q == S_DONE);
   assign bird_y = bird_y_q;
   assign bird_vel = bird_vel_q;
   assign on_ground = on_ground_q;

`ifdef BIRD_PIXEL_EN
   localparam logic [10:0] XL = 11'(BIRD_X);
   localparam logic [10:0] XH = 11'(BIRD_X + BIRD_W);
   localparam logic [9:0] BH = 10'(BIRD_H);

   logic [9:0] ytop;
   logic [9:0] ybot;

   assign ytop = {1'b0, bird_y_q};
   assign ybot = ytop + BH;
   assign bird_pixel = ({1'b0, x} >= XL) && ({1'b0, x} < XH)
                    && ({1'b0, y} >= ytop) && ({1'b0, y} < ybot);
`endif

endmodule

// File: tb/tb_bird_update.sv
// Self-checking bench for bird_update against a rule-level physics model.
// Uses TICK_DIV=4 so physics ticks arrive every few cycles.
module tb_bird_update;

   localparam int TD = 4;

   logic clk = 1'b0;
   logic resetGame_n;
   logic press;
   logic update_bird;
   logic birdfinish;
   logic [8:0] bird_y;
   logic [7:0] bird_vel;
   logic on_ground;

   int errors = 0;
   int checks = 0;

   int n;
   bit tick_m, flap_m, prev_m;
   int y_m, v_m;
   bit g_m;

   bird_update #(.TICK_DIV(TD)) dut (
      .clk(clk),
      .resetGame_n(resetGame_n),
      .press(press),
      .update_bird(update_bird),
      .birdfinish(birdfinish),
      .bird_y(bird_y),
      .bird_vel(bird_vel),
      .on_ground(on_ground)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int vel_s();
      return int'($signed(bird_vel));
   endfunction

   task automatic model_reset();
      n = 0;
      tick_m = 0;
      flap_m = 0;
      prev_m = 0;
      y_m = 240;
      v_m = 0;
      g_m = 0;
   endtask

   // One clock edge; model pending flags follow the event rules.
   task automatic cyc(input bit consume);
      bit pe;
      @(posedge clk);
      n++;
      pe = press && !prev_m;
      prev_m = press;
      if ((n % TD) == 0) tick_m = 1;
      else if (consume) tick_m = 0;
      if (pe) flap_m = 1;
      else if (consume) flap_m = 0;
      @(negedge clk);
   endtask

   task automatic wait_tick();
      for (int i = 0; i < 2 * TD && !tick_m; i++) cyc(0);
      check("tick_wait", int'(tick_m), 1);
   endtask

   task automatic do_update(input bit drop, input bit pmid);
      bit phys, fl;
      int s, k;
      update_bird = 1;
      phys = tick_m;
      cyc(0);
      if (!phys) begin
         check("fin_fast", int'(birdfinish), 1);
         check("y_hold", int'(bird_y), y_m);
      end else begin
         check("fin_early", int'(birdfinish), 0);
         if (drop) update_bird = 0;
         fl = flap_m;
         if (pmid) press = 1'($urandom % 2);
         cyc(1);
         if (fl) v_m = -8;
         else v_m = (v_m + 1 > 10) ? 10 : v_m + 1;
         check("vel_step", vel_s(), v_m);
         cyc(0);
         s = y_m + v_m;
         if (s < 0) begin
            y_m = 0;
            v_m = 0;
         end else if (s >= 440) begin
            y_m = 440;
            v_m = 0;
         end else begin
            y_m = s;
         end
         g_m = (y_m == 440);
         check("fin", int'(birdfinish), 1);
         check("y", int'(bird_y), y_m);
         check("vel", vel_s(), v_m);
         check("gnd", int'(on_ground), int'(g_m));
      end
      cyc(0);
      check("fin_once", int'(birdfinish), 0);
      k = $urandom % 3;
      repeat (k) cyc(0);
      update_bird = 0;
      cyc(0);
   endtask

   initial begin
      int pulses;
      int ey[3];
      ey = '{241, 243, 246};
      resetGame_n = 0;
      press = 0;
      update_bird = 0;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      check("rst_y", int'(bird_y), 240);
      check("rst_vel", vel_s(), 0);
      check("rst_fin", int'(birdfinish), 0);
      check("rst_gnd", int'(on_ground), 0);
      resetGame_n = 1;

      update_bird = 1;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         cyc(0);
         if (i == 0) check("lat1", int'(birdfinish), 1);
         pulses += int'(birdfinish);
      end
      check("one_pulse", pulses, 1);
      check("y_nophys", int'(bird_y), 240);
      update_bird = 0;
      cyc(0);

      for (int j = 0; j < 3; j++) begin
         wait_tick();
         do_update(0, 0);
         check("grav_v", vel_s(), j + 1);
         check("grav_y", int'(bird_y), ey[j]);
      end

      press = 1;
      cyc(0);
      wait_tick();
      do_update(0, 0);
      check("flap_v", vel_s(), -8);
      check("flap_y", int'(bird_y), 238);
      wait_tick();
      do_update(0, 0);
      check("held_v", vel_s(), -7);
      check("held_y", int'(bird_y), 231);

      for (int i = 0; i < 80 && !g_m; i++) begin
         wait_tick();
         do_update(0, 0);
      end
      check("floor_y", int'(bird_y), 440);
      check("floor_g", int'(on_ground), 1);
      check("floor_v", vel_s(), 0);

      for (int i = 0; i < 80 && !(y_m == 0 && v_m == 0); i++) begin
         press = 0;
         cyc(0);
         press = 1;
         cyc(0);
         wait_tick();
         do_update(0, 0);
      end
      check("top_y", int'(bird_y), 0);
      check("top_v", vel_s(), 0);

      for (int t = 0; t < 150; t++) begin
         int gap;
         gap = $urandom % 6;
         for (int i = 0; i < gap; i++) begin
            if ($urandom % 3 == 0) press = ~press;
            cyc(0);
         end
         do_update(($urandom % 4) == 0, ($urandom % 3) == 0);
      end

      wait_tick();
      update_bird = 1;
      cyc(0);
      cyc(1);
      resetGame_n = 0;
      #1;
      check("mid_rst_y", int'(bird_y), 240);
      check("mid_rst_v", vel_s(), 0);
      check("mid_rst_g", int'(on_ground), 0);
      check("mid_rst_f", int'(birdfinish), 0);
      update_bird = 0;
      press = 0;
      @(negedge clk);
      resetGame_n = 1;
      model_reset();
      for (int t = 0; t < 4; t++) begin
         wait_tick();
         do_update(0, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
